// File: rtl/bpu_table_ctrl.sv
// Branch-predictor counter table controller: sweeps the table to a weak
// not-taken value after reset/flush, serves one registered lookup per cycle,
// applies one resolved-branch counter update per cycle, and counts mispredicts.
module bpu_table_ctrl #(
  parameter int STEP_NUM = 4,
  parameter int INDEX_W  = 4,
  parameter int PC_W     = 12,
  parameter int MISS_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  output logic              ready_o,
  input  logic              pred_req_i,
  input  logic [PC_W-1:0]   pred_pc_i,
  output logic              pred_valid_o,
  output logic              pred_jump_o,
  input  logic              upd_valid_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic              upd_pred_i,
  output logic [MISS_W-1:0] miss_cnt_o
);

  localparam int CW    = $clog2(STEP_NUM);
  localparam int DEPTH = 2 ** INDEX_W;

  localparam logic [CW-1:0]      INIT_VAL = CW'(STEP_NUM / 2 - 1);
  localparam logic [CW-1:0]      TAKEN_TH = CW'(STEP_NUM / 2);
  localparam logic [CW-1:0]      MAX_VAL  = CW'(STEP_NUM - 1);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);
  localparam logic [MISS_W-1:0]  MISS_MAX = {MISS_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state, next_state;
  logic [INDEX_W-1:0] ptr, next_ptr;

  logic [CW-1:0]      tbl [DEPTH];

  logic [INDEX_W-1:0] pred_idx, upd_idx;
  logic [CW-1:0]      upd_cur, upd_next;
  logic               upd_accept, sweep_write;

  // Only the low PC bits select an entry; upper bits alias on purpose.
  assign pred_idx = pred_pc_i[INDEX_W-1:0];
  assign upd_idx  = upd_pc_i[INDEX_W-1:0];

  generate
    if (PC_W > INDEX_W) begin : g_pc_high
      logic unused_pc_high;
      assign unused_pc_high = ^{pred_pc_i[PC_W-1:INDEX_W], upd_pc_i[PC_W-1:INDEX_W]};
    end
  endgenerate

  // Updates arriving alongside a flush or while not ready are dropped.
  assign upd_accept  = upd_valid_i && ready_o && !flush_i && !rst_i;
  assign sweep_write = (state == ST_INIT) && !flush_i && !rst_i;

  // FSM state and sweep pointer registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // Next-state logic: flush restarts the sweep; the sweep ends after the last entry.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    ready_o    = (state == ST_READY);
    if (flush_i) begin
      next_state = ST_INIT;
      next_ptr   = '0;
    end else if (state == ST_INIT) begin
      next_ptr = ptr + INDEX_W'(1);
      if (ptr == LAST_IDX) begin
        next_state = ST_READY;
      end
    end
  end

  // Saturating counter step for the resolved branch.
  always_comb begin
    upd_cur  = tbl[upd_idx];
    upd_next = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != MAX_VAL) upd_next = upd_cur + CW'(1);
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - CW'(1);
    end
  end

  // Table write port: init sweep or accepted update (never both at once).
  // NOTE: the table storage has no reset; its contents are defined by the
  // init sweep, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (sweep_write) begin
      tbl[ptr] <= INIT_VAL;
    end else if (upd_accept) begin
      tbl[upd_idx] <= upd_next;
    end
  end

  // Registered lookup; reads the pre-update entry on a same-index collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_o <= 1'b0;
      pred_jump_o  <= 1'b0;
    end else begin
      pred_valid_o <= pred_req_i && ready_o;
      pred_jump_o  <= pred_req_i && ready_o && (tbl[pred_idx] >= TAKEN_TH);
    end
  end

  // Saturating mispredict counter; survives flush, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_o <= '0;
    end else if (upd_accept && (upd_pred_i != upd_taken_i) && (miss_cnt_o != MISS_MAX)) begin
      miss_cnt_o <= miss_cnt_o + MISS_W'(1);
    end
  end

endmodule

// File: tb/tb_bpu_table_ctrl.sv
// Self-checking bench for bpu_table_ctrl: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_bpu_table_ctrl;

  localparam int STEP_NUM = 4;
  localparam int INDEX_W  = 4;
  localparam int PC_W     = 12;
  localparam int DEPTH    = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            pred_req_i = 1'b0;
  logic [PC_W-1:0] pred_pc_i = '0;
  logic            upd_valid_i = 1'b0;
  logic [PC_W-1:0] upd_pc_i = '0;
  logic            upd_taken_i = 1'b0;
  logic            upd_pred_i = 1'b0;

  logic        ready_o, pred_valid_o, pred_jump_o;
  logic [15:0] miss_cnt_o;
  logic        ready2, pv2, pj2;
  logic [1:0]  miss2;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bpu_table_ctrl #(.STEP_NUM(STEP_NUM), .INDEX_W(INDEX_W), .PC_W(PC_W), .MISS_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ready_o(ready_o),
    .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
    .pred_valid_o(pred_valid_o), .pred_jump_o(pred_jump_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_pred_i(upd_pred_i), .miss_cnt_o(miss_cnt_o)
  );

  bpu_table_ctrl #(.STEP_NUM(STEP_NUM), .INDEX_W(INDEX_W), .PC_W(PC_W), .MISS_W(2)) dut_narrow (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ready_o(ready2),
    .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
    .pred_valid_o(pv2), .pred_jump_o(pj2),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_pred_i(upd_pred_i), .miss_cnt_o(miss2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_tbl [DEPTH];
  bit m_ready = 1'b0;
  int m_init_left = 0;
  bit m_pv = 1'b0, m_pj = 1'b0;
  int m_miss = 0, m_miss2 = 0;
  bit started = 1'b0;

  function automatic int pc_idx(input logic [PC_W-1:0] pc);
    return int'(pc) % DEPTH;
  endfunction

  function automatic int ctr_step(input int v, input bit taken);
    if (taken) return (v + 1 > STEP_NUM - 1) ? STEP_NUM - 1 : v + 1;
    return (v - 1 < 0) ? 0 : v - 1;
  endfunction

  always @(posedge clk_i) begin
    started <= 1'b1;
    if (rst_i) begin
      m_ready     <= 1'b0;
      m_init_left <= DEPTH;
      m_pv        <= 1'b0;
      m_pj        <= 1'b0;
      m_miss      <= 0;
      m_miss2     <= 0;
    end else begin
      m_pv <= pred_req_i && m_ready;
      m_pj <= pred_req_i && m_ready && (m_tbl[pc_idx(pred_pc_i)] >= STEP_NUM / 2);
      if (flush_i) begin
        m_ready     <= 1'b0;
        m_init_left <= DEPTH;
      end else if (!m_ready) begin
        m_init_left <= m_init_left - 1;
        if (m_init_left == 1) begin
          m_ready <= 1'b1;
          foreach (m_tbl[i]) m_tbl[i] <= STEP_NUM / 2 - 1;
        end
      end
      if (upd_valid_i && m_ready && !flush_i) begin
        m_tbl[pc_idx(upd_pc_i)] <= ctr_step(m_tbl[pc_idx(upd_pc_i)], upd_taken_i);
        if (upd_pred_i != upd_taken_i) begin
          m_miss  <= (m_miss  == 65535) ? m_miss  : m_miss + 1;
          m_miss2 <= (m_miss2 == 3)     ? m_miss2 : m_miss2 + 1;
        end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk_i) begin
    if (started) begin
      check("cmp_ready", ready_o, m_ready);
      check("cmp_pred_valid", pred_valid_o, m_pv);
      check("cmp_pred_jump", pred_jump_o, m_pj);
      check("cmp_miss", miss_cnt_o, m_miss);
      check("cmp_ready_narrow", ready2, m_ready);
      check("cmp_miss_narrow", miss2, m_miss2);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
    flush_i     = 1'b0;
    pred_req_i  = 1'b0;
    upd_valid_i = 1'b0;
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc, input bit exp, input string name);
    pred_req_i = 1'b1;
    pred_pc_i  = pc;
    step();
    check({name, "_valid"}, pred_valid_o, 1);
    check(name, pred_jump_o, exp);
  endtask

  task automatic upd(input logic [PC_W-1:0] pc, input bit taken, input bit pred);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = taken;
    upd_pred_i  = pred;
    step();
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready_o && n < 40) begin
      step();
      n++;
    end
    check(name, n, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Init timing: two reset cycles, then 16 sweep cycles.
    step();
    step();
    check("reset_ready", ready_o, 0);
    check("reset_miss", miss_cnt_o, 0);
    rst_i      = 1'b0;
    pred_req_i = 1'b1;
    pred_pc_i  = 12'h005;
    step();
    check("init_lookup_valid", pred_valid_o, 0);
    begin
      int n = 1;
      while (!ready_o && n < 40) begin
        step();
        n++;
      end
      check("init_len", n, 16);
    end
    lookup(12'h005, 1'b0, "first_lookup");

    // Saturation up.
    upd(12'h005, 1'b1, 1'b1);
    lookup(12'h005, 1'b1, "up_1to2");
    repeat (3) upd(12'h005, 1'b1, 1'b1);
    upd(12'h005, 1'b0, 1'b0);
    lookup(12'h005, 1'b1, "up_sat_then_down");

    // Saturation down and aliasing.
    repeat (5) upd(12'h005, 1'b0, 1'b0);
    lookup(12'h005, 1'b0, "down_sat");
    repeat (2) upd(12'h015, 1'b1, 1'b1);
    lookup(12'h005, 1'b1, "alias_015");
    lookup(12'h006, 1'b0, "other_entry");

    // Same-cycle lookup and update: read-before-write.
    upd(12'h005, 1'b0, 1'b0);
    pred_req_i  = 1'b1;
    pred_pc_i   = 12'h005;
    upd_valid_i = 1'b1;
    upd_pc_i    = 12'h005;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b1;
    step();
    check("hazard_valid", pred_valid_o, 1);
    check("hazard_old_value", pred_jump_o, 0);
    lookup(12'h005, 1'b1, "hazard_new_value");

    // Mispredict counter: 3 mismatches and 2 matches, then 2 more mismatches.
    upd(12'h007, 1'b1, 1'b0);
    upd(12'h007, 1'b1, 1'b1);
    upd(12'h007, 1'b0, 1'b1);
    upd(12'h007, 1'b0, 1'b0);
    upd(12'h007, 1'b1, 1'b0);
    check("miss_3", miss_cnt_o, 3);
    upd(12'h007, 1'b0, 1'b1);
    upd(12'h007, 1'b1, 1'b0);
    check("miss_5", miss_cnt_o, 5);
    check("miss_narrow_sat", miss2, 3);

    // Flush in READY with a mispredicting update in the same cycle.
    flush_i     = 1'b1;
    upd_valid_i = 1'b1;
    upd_pc_i    = 12'h000;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    step();
    check("flush_ready_low", ready_o, 0);
    wait_ready("flush_len");
    check("flush_keeps_miss", miss_cnt_o, 5);
    for (int i = 0; i < DEPTH; i++) lookup(PC_W'(i), 1'b0, "flush_entry");

    // Reset at sweep pointer 7.
    flush_i = 1'b1;
    step();
    repeat (7) step();
    check("mid_sweep_not_ready", ready_o, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    wait_ready("reset_mid_sweep_len");
    check("reset_clears_miss", miss_cnt_o, 0);
    lookup(12'h005, 1'b0, "after_reset_lookup");

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
